// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter.
//   Mode encodings for in_mode / mode registers: SLL, SRL, SRA, ROL.
//   FSM state type used by shift_unit_seq: IDLE, SHIFT, DONE.
package shift_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// One log2 shifter stage: shifts a WIDTH-bit value by 2^k in the selected mode.
// Purely combinational; the sequencer reuses this single instance for every
// stage by stepping k, instead of building LOG2W copies.
// Ports:
//   data_in   in   WIDTH  value to shift
//   k         in   KW     stage index, shift amount is 2^k
//   mode      in   2      SLL / SRL / SRA / ROL
//   data_out  out  WIDTH  shifted value
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2W = 5,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out
);

  logic [LOG2W-1:0] amt;
  logic [LOG2W:0]   amt_comp;

  // The stage amount never exceeds WIDTH/2, so it fits in LOG2W bits and the
  // rotate complement (WIDTH - amt) never reaches WIDTH itself. SRA reads the
  // sign from the current value, so the sign survives every later stage.
  always_comb begin
    amt      = LOG2W'(1) << k;
    amt_comp = (LOG2W+1)'(WIDTH) - {1'b0, amt};
    data_out = data_in;
    case (mode)
      SH_SLL:  data_out = data_in << amt;
      SH_SRL:  data_out = data_in >> amt;
      SH_SRA:  data_out = $unsigned($signed(data_in) >>> amt);
      SH_ROL:  data_out = (data_in << amt) | (data_in >> amt_comp);
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle barrel shifter for the processor shift path. An accepted
// operation walks through LOG2W stages, one per clock, applying a shift by
// 2^k when bit k of the shift amount is set. Latency is fixed at LOG2W cycles
// regardless of shamt. Valid/ready handshakes on both sides let the execute
// stage stall around it; a result can be drained and a new operation accepted
// in the same cycle.
// Ports:
//   clock      in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      operand, shamt and mode valid
//   in_ready   out  1      an operation is accepted this cycle
//   in_data    in   WIDTH  operand
//   in_shamt   in   LOG2W  shift amount
//   in_mode    in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result this cycle
//   out_data   out  WIDTH  shifted result
//   out_zero   out  1      out_data is zero
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int            KW     = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LOG2W - 1);

  state_t           state;
  state_t           state_nx;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] data_r;
  logic [LOG2W-1:0] shamt_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] stage_shifted;
  logic [WIDTH-1:0] stage_out;
  logic             last_stage;
  logic             accept;

  shift_stage #(
    .WIDTH (WIDTH),
    .LOG2W (LOG2W),
    .KW    (KW)
  ) u_stage (
    .data_in  (data_r),
    .k        (k),
    .mode     (mode_r),
    .data_out (stage_shifted)
  );

  // Stage k only takes effect when the matching shamt bit is set; otherwise
  // the working value passes through so latency stays constant.
  always_comb begin
    stage_out  = shamt_r[k] ? stage_shifted : data_r;
    last_stage = (k == K_LAST);
  end

  // State register. Reset drops any in-flight operation straight back to IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs. in_ready in DONE follows out_ready
  // combinationally so a drain and a new accept can share one edge.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_stage) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_nx = in_valid ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    accept = in_valid && in_ready;
  end

  // Datapath. The working value lives in data_r; out_data is only written on
  // the final stage, so an aborted or partial shift is never visible. out_data
  // holds its value after a drain until the next result replaces it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k        <= '0;
      data_r   <= '0;
      shamt_r  <= '0;
      mode_r   <= SH_SLL;
      out_data <= '0;
      out_zero <= 1'b1;
    end else if (accept) begin
      data_r  <= in_data;
      shamt_r <= in_shamt;
      mode_r  <= in_mode;
      k       <= '0;
    end else if (state == ST_SHIFT) begin
      data_r <= stage_out;
      k      <= last_stage ? '0 : k + 1'b1;
      if (last_stage) begin
        out_data <= stage_out;
        out_zero <= (stage_out == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH=32): directed scenarios for
// each mode, latency, backpressure and mid-operation reset, then a long
// randomized run against an arithmetic reference model.
module tb_shift_unit_seq;

  localparam int WIDTH = 32;
  localparam int LOG2W = 5;
  localparam int NUM_RANDOM = 10000;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int checks = 0;
  int errors = 0;

  shift_unit_seq #(
    .WIDTH (WIDTH),
    .LOG2W (LOG2W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference shift computed directly from the mode definitions: rotate is
  // the top half of a doubled word shifted left.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input logic [1:0] m);
    logic [63:0] w;
    case (m)
      2'd0: return d << sh;
      2'd1: return d >> sh;
      2'd2: return $unsigned($signed(d) >>> sh);
      default: begin
        w = {d, d} << sh;
        return w[63:32];
      end
    endcase
  endfunction

  // Offer one operation from IDLE and wait for its result without draining
  // it. lat counts clock edges from the accepting edge to out_valid.
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] sh,
                               input logic [1:0] m, output int lat, output bit ok);
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_mode   = m;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    ok = out_valid;
  endtask

  // Drain the presented result.
  task automatic consumeResult();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data);
    end
    checks++;
    if (out_zero !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_out_zero: got %b expected 1", out_zero);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_sll_latency();
    int lat;
    bit ok;
    applyStimulus(32'h0000_0001, 5'd2, 2'b00, lat, ok);
    checks++;
    if (!ok || lat != 5) begin
      errors++; $display("[TB] FAIL sll_latency: got %0d expected 5", lat);
    end
    checks++;
    if (out_data !== 32'h0000_0004) begin
      errors++; $display("[TB] FAIL sll_data: got %h expected 00000004", out_data);
    end
    consumeResult();
  endtask

  task automatic test_right_shifts();
    int lat;
    bit ok;
    applyStimulus(32'h8000_0000, 5'd31, 2'b10, lat, ok);
    checks++;
    if (!ok || out_data !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL sra_31: got %h expected ffffffff", out_data);
    end
    consumeResult();
    applyStimulus(32'h8000_0000, 5'd31, 2'b01, lat, ok);
    checks++;
    if (!ok || out_data !== 32'h0000_0001) begin
      errors++; $display("[TB] FAIL srl_31: got %h expected 00000001", out_data);
    end
    consumeResult();
    applyStimulus(32'h0000_0001, 5'd1, 2'b01, lat, ok);
    checks++;
    if (!ok || out_data !== 32'h0) begin
      errors++; $display("[TB] FAIL srl_to_zero: got %h expected 00000000", out_data);
    end
    checks++;
    if (out_zero !== 1'b1) begin
      errors++; $display("[TB] FAIL srl_zero_flag: got %b expected 1", out_zero);
    end
    consumeResult();
  endtask

  task automatic test_rotate();
    int lat;
    bit ok;
    applyStimulus(32'h8000_0001, 5'd1, 2'b11, lat, ok);
    checks++;
    if (!ok || out_data !== 32'h0000_0003) begin
      errors++; $display("[TB] FAIL rol_1: got %h expected 00000003", out_data);
    end
    checks++;
    if (out_zero !== 1'b0) begin
      errors++; $display("[TB] FAIL rol_zero_flag: got %b expected 0", out_zero);
    end
    consumeResult();
    applyStimulus(32'h1234_5678, 5'd0, 2'b11, lat, ok);
    checks++;
    if (!ok || out_data !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL rol_0: got %h expected 12345678", out_data);
    end
    checks++;
    if (lat != 5) begin
      errors++; $display("[TB] FAIL rol_0_latency: got %0d expected 5", lat);
    end
    consumeResult();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    applyStimulus(32'hDEAD_BEEF, 5'd4, 2'b01, lat, ok);
    checks++;
    if (!ok || out_data !== 32'h0DEA_DBEE) begin
      errors++; $display("[TB] FAIL bp_first: got %h expected 0deadbee", out_data);
    end
    in_valid  = 1'b1;
    in_data   = 32'h0000_00FF;
    in_shamt  = 5'd8;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_in_ready_%0d: got %b expected 0", c, in_ready);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0DEA_DBEE) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid %b data %h expected 1 0deadbee",
                 c, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checks++;
    if (lat != 5) begin
      errors++; $display("[TB] FAIL b2b_latency: got %0d expected 5", lat);
    end
    checks++;
    if (out_data !== 32'h0000_FF00) begin
      errors++; $display("[TB] FAIL b2b_data: got %h expected 0000ff00", out_data);
    end
    consumeResult();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    in_valid = 1'b1;
    in_data  = 32'h1234_ABCD;
    in_shamt = 5'd7;
    in_mode  = 2'b11;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_async: got valid %b data %h zero %b expected 0 00000000 1",
               out_valid, out_data, out_zero);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_stale_valid: got %b expected 0", out_valid);
      end
    end
    applyStimulus(32'hF000_0000, 5'd4, 2'b10, lat, ok);
    checks++;
    if (!ok || lat != 5 || out_data !== 32'hFF00_0000) begin
      errors++;
      $display("[TB] FAIL midreset_next_op: got %h lat %0d expected ff000000 lat 5",
               out_data, lat);
    end
    consumeResult();
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    while (recv < NUM_RANDOM && cyc < 90000) begin
      in_valid  = (sent < NUM_RANDOM) && ($urandom_range(0, 7) != 0);
      in_data   = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 7) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra_result: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++; $display("[TB] FAIL rand_data_%0d: got %h expected %h", recv, out_data, e);
          end
          checks++;
          if (out_zero !== (e == 32'h0)) begin
            errors++;
            $display("[TB] FAIL rand_zero_%0d: got %b expected %b", recv, out_zero, e == 32'h0);
          end
        end
        recv++;
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (recv != NUM_RANDOM || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d results %0d pending expected %0d results 0 pending",
               recv, exp_q.size(), NUM_RANDOM);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_sll_latency();
    test_right_shifts();
    test_rotate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
